// File: rtl/operand_feeder_if.sv
// Host operand channel plus the byte-wide four-phase link to the divider.
// master = operand_feeder, slave = host/divider side.
interface operand_feeder_if;
    logic        op_valid;
    logic [15:0] op_dividend;
    logic [15:0] op_divisor;
    logic        op_ready;
    logic        ready_for_input;
    logic        data_accepted;
    logic        data_ready;
    logic [7:0]  bus_byte;

    modport master (
        input  op_valid,
        input  op_dividend,
        input  op_divisor,
        input  ready_for_input,
        input  data_accepted,
        output op_ready,
        output data_ready,
        output bus_byte
    );

    modport slave (
        output op_valid,
        output op_dividend,
        output op_divisor,
        output ready_for_input,
        output data_accepted,
        input  op_ready,
        input  data_ready,
        input  bus_byte
    );
endinterface

// File: rtl/operand_feeder.sv
// Buffers dividend/divisor pairs and serialises each one as four bytes
// over the data_ready/data_accepted link, with per-phase timeout.
module operand_feeder #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    operand_feeder_if.master              bus,
    output logic                          busy,
    output logic                          pair_sent,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          timeout_err,
    input  logic                          err_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_REL,
        S_ABORT
    } state_t;

    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push, pop;
    logic [31:0]   head;

    state_t        state_q;
    logic [23:0]   shreg_q;
    logic [1:0]    idx_q;
    logic [TW-1:0] timer_q;
    logic          dr_q, busy_q, sent_q, err_q;
    logic [7:0]    byte_q;

    assign bus.op_ready = (count_q < CW'(FIFO_DEPTH));
    assign push = bus.op_valid && bus.op_ready;
    assign pop  = (state_q == S_IDLE) && (count_q != '0)
               && bus.ready_for_input;
    assign head = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {bus.op_dividend, bus.op_divisor};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    // Outputs are registered alongside the state they belong to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            timer_q <= '0;
            dr_q    <= 1'b0;
            byte_q  <= '0;
            busy_q  <= 1'b0;
            sent_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sent_q <= 1'b0;
            if (err_clr) err_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        state_q <= S_SEND;
                        byte_q  <= head[31:24];
                        shreg_q <= head[23:0];
                        idx_q   <= '0;
                        timer_q <= '0;
                        dr_q    <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (bus.data_accepted) begin
                        state_q <= S_REL;
                        timer_q <= '0;
                        dr_q    <= 1'b0;
                    end else if (timer_q == TLAST) begin
                        state_q <= S_ABORT;
                        dr_q    <= 1'b0;
                        byte_q  <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_REL: begin
                    if (!bus.data_accepted) begin
                        if (idx_q == 2'd3) begin
                            state_q <= S_IDLE;
                            sent_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            byte_q  <= '0;
                        end else begin
                            state_q <= S_SEND;
                            idx_q   <= idx_q + 1'b1;
                            byte_q  <= shreg_q[23:16];
                            shreg_q <= {shreg_q[15:0], 8'h00};
                            timer_q <= '0;
                            dr_q    <= 1'b1;
                        end
                    end else if (timer_q == TLAST) begin
                        state_q <= S_ABORT;
                        byte_q  <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_ABORT: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.data_ready = dr_q;
    assign bus.bus_byte   = byte_q;
    assign busy           = busy_q;
    assign pair_sent      = sent_q;
    assign fifo_count     = count_q;
    assign timeout_err    = err_q;
endmodule

// File: tb/tb_operand_feeder.sv
// Randomised bench for operand_feeder: a four-phase sink model captures
// bytes and a pair-level queue model predicts what must come out.
module tb_operand_feeder;
    localparam int DEPTH = 4;
    localparam int TO    = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy, pair_sent, timeout_err, err_clr;
    logic [2:0] fifo_count;

    operand_feeder_if ifc ();

    operand_feeder #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (ifc),
        .busy        (busy),
        .pair_sent   (pair_sent),
        .fifo_count  (fifo_count),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int sent_n = 0;

    logic [31:0] mq [$];
    logic [7:0]  cap [$];

    int   ack_dly = 0;
    int   rel_dly = 0;
    bit   mute    = 1'b0;
    int   scnt    = 0;
    logic [7:0] first_b;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h @%0t", tag, obs, exp,
                     $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // four-phase sink with programmable ack/release delays
    always @(negedge clk) begin
        if (!rst) begin
            ifc.data_accepted = 1'b0;
            scnt = 0;
        end else if (!ifc.data_accepted) begin
            if (ifc.data_ready && !mute) begin
                if (scnt == 0) first_b = ifc.bus_byte;
                if (scnt >= ack_dly) begin
                    if (ack_dly > 0)
                        chk("stable", ifc.bus_byte, first_b);
                    cap.push_back(ifc.bus_byte);
                    ifc.data_accepted = 1'b1;
                    scnt = 0;
                end else begin
                    scnt++;
                end
            end else begin
                scnt = 0;
            end
        end else if (!ifc.data_ready) begin
            if (scnt >= rel_dly) begin
                ifc.data_accepted = 1'b0;
                scnt = 0;
            end else begin
                scnt++;
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] got;
        logic [31:0] exp;
        if (rst && pair_sent) begin
            sent_n++;
            got = '0;
            foreach (cap[i]) got = {got[23:0], cap[i]};
            exp = '0;
            if (mq.size() != 0) exp = mq.pop_front();
            chk("nbytes", cap.size(), 4);
            chk("pair", got, exp);
            cap.delete();
        end
    end

    task automatic push(input logic [15:0] d, input logic [15:0] m,
                        output bit acc);
        @(negedge clk);
        ifc.op_valid    = 1'b1;
        ifc.op_dividend = d;
        ifc.op_divisor  = m;
        acc = ifc.op_ready;
        if (acc) mq.push_back({d, m});
        @(posedge clk);
        #1 ifc.op_valid = 1'b0;
    endtask

    task automatic wait_dr(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ifc.data_ready && n < budget);
        chk("dr_rise", ifc.data_ready, 1'b1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        ifc.ready_for_input = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || fifo_count != 0 || ifc.data_accepted)
                   && n < budget);
        @(negedge clk);
        chk("drain_busy", busy, 1'b0);
        chk("drain_cnt", fifo_count, 0);
        chk("drain_mq", mq.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        bit acc;
        int n, c1, s0, stray;
        logic [15:0] d, m;

        rst = 1'b0;
        err_clr = 1'b0;
        ifc.op_valid = 1'b0;
        ifc.op_dividend = '0;
        ifc.op_divisor = '0;
        ifc.ready_for_input = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rdy", ifc.op_ready, 1'b1);
        chk("rst_dr", ifc.data_ready, 1'b0);
        chk("rst_byte", ifc.bus_byte, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sent", pair_sent, 1'b0);
        chk("rst_cnt", fifo_count, 0);
        chk("rst_err", timeout_err, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;

        // single pair, immediate sink
        ifc.ready_for_input = 1'b1;
        push(16'hA53C, 16'h0012, acc);
        chk("p1_acc", acc, 1'b1);
        wait_dr(10);
        c1 = cyc;
        chk("p1_b0", ifc.bus_byte, 8'hA5);
        n = 0;
        while (!pair_sent && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("p1_lat", cyc - c1, 8);
        @(negedge clk);
        chk("p1_pulse", pair_sent, 1'b0);
        drain(50);

        // fill the FIFO with downstream stalled
        ifc.ready_for_input = 1'b0;
        s0 = sent_n;
        for (int i = 0; i < 5; i++) begin
            push(16'($urandom), 16'($urandom), acc);
            chk("full_acc", acc, i < DEPTH);
        end
        chk("full_rdy", ifc.op_ready, 1'b0);
        chk("full_cnt", fifo_count, DEPTH);
        drain(300);
        chk("full_sent", sent_n - s0, DEPTH);

        // slow sink
        ack_dly = 3;
        rel_dly = 2;
        for (int i = 0; i < 3; i++)
            push(16'($urandom), 16'($urandom), acc);
        drain(400);

        // timeout: sink never acknowledges
        ack_dly = 0;
        rel_dly = 0;
        ifc.ready_for_input = 1'b0;
        push(16'($urandom), 16'($urandom), acc);
        push(16'($urandom), 16'($urandom), acc);
        mute = 1'b1;
        ifc.ready_for_input = 1'b1;
        wait_dr(10);
        n = 0;
        while (ifc.data_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("to_cycles", n, TO);
        chk("to_err", timeout_err, 1'b1);
        chk("to_cnt", fifo_count, 1);
        void'(mq.pop_front());
        cap.delete();
        mute = 1'b0;
        drain(100);
        chk("err_sticky", timeout_err, 1'b1);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_clr", timeout_err, 1'b0);

        // push in the same cycle as a pop
        ifc.ready_for_input = 1'b0;
        push(16'($urandom), 16'($urandom), acc);
        push(16'($urandom), 16'($urandom), acc);
        chk("sp_pre", fifo_count, 2);
        @(negedge clk);
        d = 16'($urandom);
        m = 16'($urandom);
        ifc.ready_for_input = 1'b1;
        ifc.op_valid = 1'b1;
        ifc.op_dividend = d;
        ifc.op_divisor = m;
        acc = ifc.op_ready;
        chk("sp_acc", acc, 1'b1);
        if (acc) mq.push_back({d, m});
        @(posedge clk);
        #1 ifc.op_valid = 1'b0;
        @(negedge clk);
        chk("sp_cnt", fifo_count, 2);
        drain(200);

        // asynchronous reset during byte 2
        ack_dly = 1;
        rel_dly = 1;
        ifc.ready_for_input = 1'b0;
        push(16'($urandom), 16'($urandom), acc);
        push(16'($urandom), 16'($urandom), acc);
        ifc.ready_for_input = 1'b1;
        n = 0;
        while (!(cap.size() == 2 && ifc.data_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rs_at_b2", cap.size(), 2);
        #2 rst = 1'b0;
        #1;
        chk("rs_dr", ifc.data_ready, 1'b0);
        chk("rs_byte", ifc.bus_byte, 8'h00);
        chk("rs_cnt", fifo_count, 0);
        chk("rs_busy", busy, 1'b0);
        mq.delete();
        cap.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        stray = 0;
        repeat (6) begin
            @(negedge clk);
            if (ifc.data_ready || busy) stray++;
        end
        chk("rs_stray", stray, 0);
        chk("rs_rdy", ifc.op_ready, 1'b1);

        // random traffic
        for (int k = 0; k < 24; k++) begin
            ack_dly = $urandom_range(0, 3);
            rel_dly = $urandom_range(0, 3);
            ifc.ready_for_input = ($urandom_range(0, 3) != 0);
            d = 16'($urandom);
            m = 16'($urandom);
            acc = 1'b0;
            n = 0;
            while (!acc && n < 100) begin
                push(d, m, acc);
                if (!acc) ifc.ready_for_input = 1'b1;
                n++;
            end
            chk("rnd_push", acc, 1'b1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain(2000);
        chk("rnd_err", timeout_err, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
